// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU, front panel), the
// arbiter and the main-memory model. The arbiter takes the slave view; the
// requesters/memory side takes the master view.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    // CPU requester
    logic                  cpu_req;
    logic                  cpu_read_enable;
    logic                  cpu_write_enable;
    logic                  cpu_read_type;
    logic [ADDR_WIDTH-1:0] cpu_address;
    logic [DATA_WIDTH-1:0] cpu_write_data;
    logic [DATA_WIDTH-1:0] cpu_read_data;
    logic                  cpu_finished;
    logic                  cpu_error;

    // Front-panel requester
    logic                  pnl_req;
    logic                  pnl_read_enable;
    logic                  pnl_write_enable;
    logic [ADDR_WIDTH-1:0] pnl_address;
    logic [DATA_WIDTH-1:0] pnl_write_data;
    logic [DATA_WIDTH-1:0] pnl_read_data;
    logic                  pnl_finished;
    logic                  pnl_error;

    // Memory port
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic                  mem_read_type;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_finished;

    logic [1:0]            grant_owner;

    modport slave (
        input  cpu_req, cpu_read_enable, cpu_write_enable, cpu_read_type,
        input  cpu_address, cpu_write_data,
        output cpu_read_data, cpu_finished, cpu_error,
        input  pnl_req, pnl_read_enable, pnl_write_enable, pnl_address, pnl_write_data,
        output pnl_read_data, pnl_finished, pnl_error,
        output mem_address, mem_read_enable, mem_write_enable, mem_read_type,
        output mem_write_data,
        input  mem_read_data, mem_finished,
        output grant_owner
    );

    modport master (
        output cpu_req, cpu_read_enable, cpu_write_enable, cpu_read_type,
        output cpu_address, cpu_write_data,
        input  cpu_read_data, cpu_finished, cpu_error,
        output pnl_req, pnl_read_enable, pnl_write_enable, pnl_address, pnl_write_data,
        input  pnl_read_data, pnl_finished, pnl_error,
        input  mem_address, mem_read_enable, mem_write_enable, mem_read_type,
        input  mem_write_data,
        output mem_read_data, mem_finished,
        input  grant_owner
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing the PDP8 main-memory port between the CPU
// controller and the front-panel loader. One transaction at a time:
// IDLE (arbitrate/latch) -> ACCESS (drive memory) -> RESPOND (pulse finished).
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    memory_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_t;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    // Owner/last-grant encoding: 0 = CPU, 1 = panel.
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  re_q, re_d;
    logic                  we_q, we_d;
    logic                  rtype_q, rtype_d;
    logic                  err_q, err_d;
    logic [7:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] pnl_rdata_q, pnl_rdata_d;

    logic cpu_elig, pnl_elig, pick_pnl;

    // State and transaction registers; reset drops any in-flight access silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            rtype_q     <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            re_q        <= re_d;
            we_q        <= we_d;
            rtype_q     <= rtype_d;
            err_q       <= err_d;
            count_q     <= count_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
        end
    end

    // Arbitration, request latching, timeout and read-data capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        re_d        = re_q;
        we_d        = we_q;
        rtype_d     = rtype_q;
        err_d       = err_q;
        count_d     = count_q;
        cpu_rdata_d = cpu_rdata_q;
        pnl_rdata_d = pnl_rdata_q;

        cpu_elig = bus.cpu_req && run;
        pnl_elig = bus.pnl_req;
        // Panel wins only if CPU is not eligible or CPU had the last grant.
        pick_pnl = pnl_elig && (!cpu_elig || !last_q);

        unique case (state_q)
            StIdle: begin
                if (cpu_elig || pnl_elig) begin
                    owner_d = pick_pnl;
                    count_d = '0;
                    if (pick_pnl) begin
                        addr_d  = bus.pnl_address;
                        wdata_d = bus.pnl_write_data;
                        re_d    = bus.pnl_read_enable;
                        we_d    = bus.pnl_write_enable;
                        rtype_d = 1'b1;
                    end else begin
                        addr_d  = bus.cpu_address;
                        wdata_d = bus.cpu_write_data;
                        re_d    = bus.cpu_read_enable;
                        we_d    = bus.cpu_write_enable;
                        rtype_d = bus.cpu_read_type;
                    end
                    // Neither or both strobes requested: reject without touching memory.
                    if (re_d == we_d) begin
                        err_d   = 1'b1;
                        state_d = StRespond;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                count_d = count_q + 8'd1;
                if (bus.mem_finished) begin
                    if (re_q) begin
                        if (owner_q) pnl_rdata_d = bus.mem_read_data;
                        else         cpu_rdata_d = bus.mem_read_data;
                    end
                    state_d = StRespond;
                end else if (count_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.mem_address      = '0;
        bus.mem_write_data   = '0;
        bus.mem_read_enable  = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_read_type    = 1'b0;
        bus.cpu_finished     = 1'b0;
        bus.cpu_error        = 1'b0;
        bus.pnl_finished     = 1'b0;
        bus.pnl_error        = 1'b0;
        bus.grant_owner      = 2'b00;
        bus.cpu_read_data    = cpu_rdata_q;
        bus.pnl_read_data    = pnl_rdata_q;

        if (state_q != StIdle) bus.grant_owner = owner_q ? 2'b10 : 2'b01;
        if (state_q == StAccess) begin
            bus.mem_address      = addr_q;
            bus.mem_write_data   = wdata_q;
            bus.mem_read_enable  = re_q;
            bus.mem_write_enable = we_q;
            bus.mem_read_type    = rtype_q;
        end
        if (state_q == StRespond) begin
            bus.cpu_finished = !owner_q;
            bus.cpu_error    = !owner_q && err_q;
            bus.pnl_finished = owner_q;
            bus.pnl_error    = owner_q && err_q;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: the bench plays both requesters and the
// memory. Inputs are driven and outputs sampled 1 time unit after posedge.
module tb_memory_arbiter;
    logic clk;
    logic reset;
    logic run;
    int   n_tests;
    int   n_fail;

    memory_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (12),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Grant one transaction with reqs held, finishing memory on the first ACCESS cycle.
    task automatic serve(input string tag, input logic [1:0] exp_owner,
                         input logic [11:0] exp_addr, input logic [11:0] rdata);
        tick();
        check({tag, "_grant"}, 32'(bus.grant_owner), 32'(exp_owner));
        check({tag, "_addr"}, 32'(bus.mem_address), 32'(exp_addr));
        bus.mem_finished  = 1'b1;
        bus.mem_read_data = rdata;
        tick();
        bus.mem_finished  = 1'b0;
        bus.mem_read_data = '0;
        if (exp_owner == 2'b01) check({tag, "_fin"}, 32'(bus.cpu_finished), 32'd1);
        else                    check({tag, "_fin"}, 32'(bus.pnl_finished), 32'd1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        run   = 1'b0;
        bus.cpu_req = 0; bus.cpu_read_enable = 0; bus.cpu_write_enable = 0;
        bus.cpu_read_type = 0; bus.cpu_address = '0; bus.cpu_write_data = '0;
        bus.pnl_req = 0; bus.pnl_read_enable = 0; bus.pnl_write_enable = 0;
        bus.pnl_address = '0; bus.pnl_write_data = '0;
        bus.mem_read_data = '0; bus.mem_finished = 0;
        tick();
        tick();
        check("rst_grant", 32'(bus.grant_owner), 32'd0);
        check("rst_strobes", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("rst_fin", 32'({bus.cpu_finished, bus.pnl_finished}), 32'd0);
        check("rst_rdata", 32'({bus.cpu_read_data, bus.pnl_read_data}), 32'd0);
        reset = 1'b0;
        tick();

        // Panel deposit 0200 <- 7402, memory finishes on 3rd access cycle
        bus.pnl_req = 1; bus.pnl_write_enable = 1;
        bus.pnl_address = 12'o0200; bus.pnl_write_data = 12'o7402;
        tick();
        check("dep_we", 32'(bus.mem_write_enable), 32'd1);
        check("dep_re", 32'(bus.mem_read_enable), 32'd0);
        check("dep_addr", 32'(bus.mem_address), 32'o0200);
        check("dep_wdata", 32'(bus.mem_write_data), 32'o7402);
        check("dep_grant", 32'(bus.grant_owner), 32'b10);
        tick();
        tick();
        check("dep_nofin_early", 32'(bus.pnl_finished), 32'd0);
        bus.mem_finished = 1;
        tick();
        bus.mem_finished = 0;
        check("dep_fin", 32'(bus.pnl_finished), 32'd1);
        check("dep_err", 32'(bus.pnl_error), 32'd0);
        check("dep_we_off", 32'(bus.mem_write_enable), 32'd0);
        bus.pnl_req = 0; bus.pnl_write_enable = 0;
        tick();
        check("dep_fin_pulse", 32'(bus.pnl_finished), 32'd0);
        check("dep_grant_idle", 32'(bus.grant_owner), 32'd0);

        // CPU instruction fetch from 0200
        run = 1;
        bus.cpu_req = 1; bus.cpu_read_enable = 1; bus.cpu_read_type = 0;
        bus.cpu_address = 12'o0200;
        tick();
        check("fetch_re", 32'(bus.mem_read_enable), 32'd1);
        check("fetch_rtype", 32'(bus.mem_read_type), 32'd0);
        check("fetch_grant", 32'(bus.grant_owner), 32'b01);
        bus.mem_finished = 1; bus.mem_read_data = 12'o7402;
        tick();
        bus.mem_finished = 0; bus.mem_read_data = 12'o1234;
        check("fetch_fin", 32'(bus.cpu_finished), 32'd1);
        check("fetch_rdata", 32'(bus.cpu_read_data), 32'o7402);
        check("fetch_pnl_rdata", 32'(bus.pnl_read_data), 32'd0);
        bus.cpu_req = 0;
        tick();
        check("fetch_fin_pulse", 32'(bus.cpu_finished), 32'd0);
        check("fetch_rdata_hold", 32'(bus.cpu_read_data), 32'o7402);

        // Stray mem_finished in IDLE is ignored
        bus.mem_finished = 1; bus.mem_read_data = 12'o5555;
        tick();
        bus.mem_finished = 0;
        tick();
        check("stray_fin", 32'({bus.cpu_finished, bus.pnl_finished}), 32'd0);
        check("stray_rdata", 32'(bus.cpu_read_data), 32'o7402);

        // Contention right after reset: CPU, panel, CPU
        reset = 1;
        tick();
        reset = 0;
        bus.cpu_req = 1; bus.cpu_read_enable = 1; bus.cpu_address = 12'o0100;
        bus.pnl_req = 1; bus.pnl_read_enable = 1; bus.pnl_address = 12'o0300;
        serve("cont1", 2'b01, 12'o0100, 12'o1111);
        serve("cont2", 2'b10, 12'o0300, 12'o2222);
        serve("cont3", 2'b01, 12'o0100, 12'o3333);
        bus.cpu_req = 0; bus.pnl_req = 0;
        check("cont_cpu_rdata", 32'(bus.cpu_read_data), 32'o3333);
        check("cont_pnl_rdata", 32'(bus.pnl_read_data), 32'o2222);
        tick();

        // run=0 blocks CPU grants; raising run grants next cycle
        run = 0;
        bus.cpu_req = 1; bus.cpu_read_enable = 1; bus.cpu_read_type = 1;
        bus.cpu_address = 12'o0500;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant_owner != 2'b00 || bus.mem_read_enable) seen++;
        end
        check("run0_nogrant", 32'(seen), 32'd0);
        run = 1;
        tick();
        check("run1_grant", 32'(bus.grant_owner), 32'b01);
        check("run1_rtype", 32'(bus.mem_read_type), 32'd1);
        // Dropping run mid-access does not abort
        run = 0;
        tick();
        tick();
        check("rundrop_re", 32'(bus.mem_read_enable), 32'd1);
        bus.mem_finished = 1; bus.mem_read_data = 12'o4321;
        tick();
        bus.mem_finished = 0;
        check("rundrop_fin", 32'(bus.cpu_finished), 32'd1);
        check("rundrop_rdata", 32'(bus.cpu_read_data), 32'o4321);
        bus.cpu_req = 0;
        tick();

        // Illegal CPU request: read and write both set
        run = 1;
        bus.cpu_req = 1; bus.cpu_read_enable = 1; bus.cpu_write_enable = 1;
        tick();
        check("ill_strobes", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("ill_fin", 32'(bus.cpu_finished), 32'd1);
        check("ill_err", 32'(bus.cpu_error), 32'd1);
        check("ill_rdata", 32'(bus.cpu_read_data), 32'o4321);
        bus.cpu_req = 0; bus.cpu_read_enable = 0; bus.cpu_write_enable = 0;
        tick();
        check("ill_err_pulse", 32'(bus.cpu_error), 32'd0);

        // Illegal panel request: neither strobe set
        bus.pnl_req = 1; bus.pnl_read_enable = 0; bus.pnl_write_enable = 0;
        tick();
        check("pill_fin_err", 32'({bus.pnl_finished, bus.pnl_error}), 32'b11);
        bus.pnl_req = 0;
        tick();

        // Timeout on a panel read: memory never answers
        bus.pnl_req = 1; bus.pnl_read_enable = 1; bus.pnl_address = 12'o0400;
        bus.mem_read_data = 12'o7777;
        tick();
        check("to_rtype", 32'(bus.mem_read_type), 32'd1);
        n = 0;
        while (bus.mem_read_enable && n < 200) begin
            n++;
            tick();
        end
        check("to_cycles", 32'(n), 32'd64);
        check("to_fin", 32'(bus.pnl_finished), 32'd1);
        check("to_err", 32'(bus.pnl_error), 32'd1);
        check("to_rdata", 32'(bus.pnl_read_data), 32'o2222);
        bus.pnl_req = 0; bus.mem_read_data = '0;
        tick();

        // Reset mid-ACCESS: strobes drop at once, no finished pulse
        bus.cpu_req = 1; bus.cpu_write_enable = 1; bus.cpu_read_enable = 0;
        bus.cpu_address = 12'o0600; bus.cpu_write_data = 12'o0017;
        tick();
        tick();
        check("rstmid_we", 32'(bus.mem_write_enable), 32'd1);
        reset = 1;
        bus.cpu_req = 0; bus.cpu_write_enable = 0;
        tick();
        check("rstmid_strobes", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("rstmid_rdata", 32'(bus.cpu_read_data), 32'd0);
        reset = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.cpu_finished || bus.pnl_finished || bus.grant_owner != 2'b00) seen++;
            tick();
        end
        check("rstmid_nofin", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
